// File: rtl/mmio_pkg.sv
// Shared widths, slot read-data array type and bridge FSM states for the MMIO slot bridge.
package mmio_pkg;
  localparam int DATA_W      = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int SLOT_ADDR_W = 6;
  // Read-data array covers the full slot decode range; slots above N_SLOTS are never selected.
  localparam int MAX_SLOTS   = 1 << SLOT_ADDR_W;

  typedef logic [DATA_W-1:0] slot_rd_array_t [MAX_SLOTS];

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } bridge_state_t;
endpackage

// File: rtl/mmio_slot_bridge_if.sv
// Host I/O bus plus slot-side bus of the MMIO slot bridge; master = host/slots, slave = bridge.
interface mmio_slot_bridge_if import mmio_pkg::*; #(
  parameter int N_SLOTS = 64
);
  logic                  io_addr_strobe;
  logic                  io_read_strobe;
  logic                  io_write_strobe;
  logic [3:0]            io_byte_enable;
  logic [31:0]           io_address;
  logic [DATA_W-1:0]     io_write_data;
  logic [DATA_W-1:0]     io_read_data;
  logic                  io_ready;
  logic                  bus_err;
  logic [N_SLOTS-1:0]    slot_cs_array;
  logic                  slot_read;
  logic                  slot_write;
  logic [REG_ADDR_W-1:0] slot_reg_addr;
  logic [DATA_W-1:0]     slot_wr_data;
  slot_rd_array_t        slot_rd_data_array;

  modport master (
    output io_addr_strobe, io_read_strobe, io_write_strobe, io_byte_enable,
           io_address, io_write_data, slot_rd_data_array,
    input  io_read_data, io_ready, bus_err, slot_cs_array, slot_read,
           slot_write, slot_reg_addr, slot_wr_data
  );

  modport slave (
    input  io_addr_strobe, io_read_strobe, io_write_strobe, io_byte_enable,
           io_address, io_write_data, slot_rd_data_array,
    output io_read_data, io_ready, bus_err, slot_cs_array, slot_read,
           slot_write, slot_reg_addr, slot_wr_data
  );
endinterface

// File: rtl/mmio_slot_decoder.sv
// Combinational window hit check, slot/register field extraction and one-hot slot select.
module mmio_slot_decoder import mmio_pkg::*; #(
  parameter logic [31:0] BRIDGE_BASE = 32'hC000_0000,
  parameter int          N_SLOTS     = 64
) (
  input  logic [31:0]            addr,
  output logic                   hit,
  output logic [SLOT_ADDR_W-1:0] slot,
  output logic [REG_ADDR_W-1:0]  reg_addr,
  output logic [N_SLOTS-1:0]     cs
);
  logic unused_addr;

  assign slot     = addr[12:7];
  assign reg_addr = addr[6:2];
  // Slot indices at or above N_SLOTS fall outside the window rather than wrapping.
  assign hit      = (addr[31:24] == BRIDGE_BASE[31:24]) &&
                    ({1'b0, slot} < (SLOT_ADDR_W+1)'(N_SLOTS));
  assign unused_addr = ^{addr[23:13], addr[1:0]};

  always_comb begin
    cs = '0;
    if (hit) cs[slot] = 1'b1;
  end
endmodule

// File: rtl/mmio_slot_bridge.sv
// Host strobe/ready bus to MMIO slot bridge: decode, fixed-latency slot read, registered response.
module mmio_slot_bridge import mmio_pkg::*; #(
  parameter logic [31:0] BRIDGE_BASE = 32'hC000_0000,
  parameter int          N_SLOTS     = 64,
  parameter int          RD_LAT      = 2
) (
  input  logic               clk,
  input  logic               reset,
  mmio_slot_bridge_if.slave  bus
);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  bridge_state_t          state;
  logic [CNT_W-1:0]       cnt;
  logic [SLOT_ADDR_W-1:0] slot_q;

  logic                   dec_hit;
  logic [SLOT_ADDR_W-1:0] dec_slot;
  logic [REG_ADDR_W-1:0]  dec_reg;
  logic [N_SLOTS-1:0]     dec_cs;
  logic                   legal_wr, legal_rd;

  mmio_slot_decoder #(
    .BRIDGE_BASE (BRIDGE_BASE),
    .N_SLOTS     (N_SLOTS)
  ) u_dec (
    .addr     (bus.io_address),
    .hit      (dec_hit),
    .slot     (dec_slot),
    .reg_addr (dec_reg),
    .cs       (dec_cs)
  );

  assign legal_wr = dec_hit && bus.io_write_strobe && !bus.io_read_strobe &&
                    (bus.io_byte_enable == 4'hF);
  assign legal_rd = dec_hit && bus.io_read_strobe && !bus.io_write_strobe;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      slot_q            <= '0;
      bus.io_ready      <= 1'b0;
      bus.bus_err       <= 1'b0;
      bus.io_read_data  <= '0;
      bus.slot_cs_array <= '0;
      bus.slot_read     <= 1'b0;
      bus.slot_write    <= 1'b0;
      bus.slot_reg_addr <= '0;
      bus.slot_wr_data  <= '0;
    end else begin
      // Response and slot qualifiers are single-cycle pulses unless re-armed below.
      bus.io_ready      <= 1'b0;
      bus.bus_err       <= 1'b0;
      bus.slot_cs_array <= '0;
      bus.slot_read     <= 1'b0;
      bus.slot_write    <= 1'b0;

      if (bus.io_addr_strobe && state != IDLE) bus.bus_err <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.io_addr_strobe) begin
            slot_q            <= dec_slot;
            bus.slot_reg_addr <= dec_reg;
            bus.slot_wr_data  <= bus.io_write_data;
            if (legal_wr) begin
              state             <= WR;
              bus.slot_cs_array <= dec_cs;
              bus.slot_write    <= 1'b1;
              bus.io_ready      <= 1'b1;
            end else if (legal_rd) begin
              state             <= RD_ISSUE;
              bus.slot_cs_array <= dec_cs;
              bus.slot_read     <= 1'b1;
            end else begin
              bus.bus_err      <= 1'b1;
              bus.io_ready     <= 1'b1;
              bus.io_read_data <= '0;
            end
          end
        end
        WR: state <= IDLE;
        RD_ISSUE: begin
          cnt   <= CNT_W'(RD_LAT - 1);
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          // Slot data is valid in the last wait cycle; capture it and respond next cycle.
          if (cnt == '0) begin
            bus.io_read_data <= bus.slot_rd_data_array[slot_q];
            bus.io_ready     <= 1'b1;
            state            <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
